// File: rtl/iagu_actfun_2d.sv
// Input-address generator for the activation-function stage: walks a 2-D
// region of pieces x rows, honours back-pressure and reports valid/last/done.
module iagu_actfun_2d #(
    parameter int ADDR_W   = 12,
    parameter int CNT_W    = 8,
    parameter int STRIDE_W = 4,
    parameter int READ_LAT = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [ADDR_W-1:0]   i_addr_start,
    input  logic [CNT_W-1:0]    i_piece_num,
    input  logic [CNT_W-1:0]    i_row_num,
    input  logic [STRIDE_W-1:0] i_stride,
    input  logic [ADDR_W-1:0]   i_row_pitch,
    input  logic                i_stall,
    output logic                o_IOB_REn,
    output logic [ADDR_W-1:0]   o_IOB_RAddr,
    output logic                o_last,
    output logic                o_dvalid,
    output logic                o_done,
    output logic                o_busy
);

    localparam int DRAIN_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [ADDR_W-1:0]   row_base_reg, row_base_next;
    logic [CNT_W-1:0]    piece_reg, piece_next;
    logic [CNT_W-1:0]    row_reg, row_next;
    logic [CNT_W-1:0]    piece_last_reg, piece_last_next;
    logic [CNT_W-1:0]    row_last_reg, row_last_next;
    logic [STRIDE_W-1:0] stride_reg, stride_next;
    logic [ADDR_W-1:0]   pitch_reg, pitch_next;
    logic [DRAIN_W-1:0]  drain_reg, drain_next;
    logic                done_reg, done_next;
    logic [READ_LAT-1:0] dvalid_reg, dvalid_next;

    logic read_en;
    logic last_read;
    logic piece_end;
    logic row_end;

    assign piece_end = (piece_reg == piece_last_reg);
    assign row_end   = (row_reg == row_last_reg);

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        row_base_next   = row_base_reg;
        piece_next      = piece_reg;
        row_next        = row_reg;
        piece_last_next = piece_last_reg;
        row_last_next   = row_last_reg;
        stride_next     = stride_reg;
        pitch_next      = pitch_reg;
        drain_next      = drain_reg;
        done_next       = 1'b0;
        read_en         = 1'b0;
        last_read       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    // Counters compare against num-1, latched once per region.
                    piece_last_next = i_piece_num - CNT_W'(1);
                    row_last_next   = i_row_num - CNT_W'(1);
                    stride_next     = i_stride;
                    pitch_next      = i_row_pitch;
                    drain_next      = '0;
                    if (i_piece_num == '0 || i_row_num == '0) begin
                        state_next = DRAIN;
                    end else begin
                        addr_next     = i_addr_start;
                        row_base_next = i_addr_start;
                        piece_next    = '0;
                        row_next      = '0;
                        state_next    = RUN;
                    end
                end
            end

            RUN: begin
                read_en = !i_stall;
                if (!i_stall) begin
                    if (!piece_end) begin
                        piece_next = piece_reg + CNT_W'(1);
                        addr_next  = addr_reg + ADDR_W'(stride_reg);
                    end else if (!row_end) begin
                        piece_next    = '0;
                        row_next      = row_reg + CNT_W'(1);
                        row_base_next = row_base_reg + pitch_reg;
                        addr_next     = row_base_reg + pitch_reg;
                    end else begin
                        last_read  = 1'b1;
                        drain_next = '0;
                        state_next = DRAIN;
                    end
                end
            end

            DRAIN: begin
                // Wait out the IOB latency so done follows the final dvalid.
                if (drain_reg == DRAIN_W'(READ_LAT - 1)) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    drain_next = drain_reg + DRAIN_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < READ_LAT; gi++) begin : g_dvalid
            if (gi == 0) begin : g_head
                assign dvalid_next[gi] = read_en;
            end else begin : g_tail
                assign dvalid_next[gi] = dvalid_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            row_base_reg   <= '0;
            piece_reg      <= '0;
            row_reg        <= '0;
            piece_last_reg <= '0;
            row_last_reg   <= '0;
            stride_reg     <= '0;
            pitch_reg      <= '0;
            drain_reg      <= '0;
            done_reg       <= 1'b0;
            dvalid_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            row_base_reg   <= row_base_next;
            piece_reg      <= piece_next;
            row_reg        <= row_next;
            piece_last_reg <= piece_last_next;
            row_last_reg   <= row_last_next;
            stride_reg     <= stride_next;
            pitch_reg      <= pitch_next;
            drain_reg      <= drain_next;
            done_reg       <= done_next;
            dvalid_reg     <= dvalid_next;
        end
    end

    assign o_IOB_REn   = read_en;
    assign o_IOB_RAddr = addr_reg;
    assign o_last      = last_read;
    assign o_dvalid    = dvalid_reg[READ_LAT-1];
    assign o_done      = done_reg;
    assign o_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_iagu_actfun_2d.sv
// Scoreboard bench for iagu_actfun_2d: expected read addresses are queued when a
// region is accepted; a negedge monitor checks reads, dvalid, done and busy.
module tb_iagu_actfun_2d;

    localparam int ADDR_W   = 12;
    localparam int CNT_W    = 8;
    localparam int STRIDE_W = 4;
    parameter  int READ_LAT = 1;
    localparam int AMASK    = (1 << ADDR_W) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   addr_start = '0;
    logic [CNT_W-1:0]    piece_num = '0;
    logic [CNT_W-1:0]    row_num = '0;
    logic [STRIDE_W-1:0] stride = '0;
    logic [ADDR_W-1:0]   row_pitch = '0;
    logic                stall = 1'b0;
    logic                ren;
    logic [ADDR_W-1:0]   raddr;
    logic                last;
    logic                dvalid;
    logic                done;
    logic                busy;

    always #5 clk = ~clk;

    iagu_actfun_2d #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .STRIDE_W(STRIDE_W), .READ_LAT(READ_LAT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_addr_start(addr_start),
        .i_piece_num(piece_num), .i_row_num(row_num), .i_stride(stride),
        .i_row_pitch(row_pitch), .i_stall(stall), .o_IOB_REn(ren),
        .o_IOB_RAddr(raddr), .o_last(last), .o_dvalid(dvalid), .o_done(done),
        .o_busy(busy)
    );

    typedef struct {
        int addr;
        bit last;
    } rd_t;

    rd_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  m_left = 0;
    int  m_done_cyc = -1;
    bit  dly [READ_LAT];
    bit  ren_now;
    bit  busy_now;
    int  ren_e;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_busy();
        return (m_left > 0) || (cyc < m_done_cyc);
    endfunction

    // Reference model: a region is a count of reads plus a done cycle that sits
    // READ_LAT+1 cycles after the final read (or after start for an empty region).
    always @(posedge clk) begin
        if (rst) begin
            m_left     = 0;
            m_done_cyc = -1;
            exp_q.delete();
            for (int i = 0; i < READ_LAT; i++) dly[i] = 1'b0;
        end else begin
            ren_now  = (m_left > 0) && !stall;
            busy_now = m_busy();
            for (int i = READ_LAT - 1; i > 0; i--) dly[i] = dly[i-1];
            dly[0] = ren_now;
            if (ren_now) begin
                m_left--;
                if (m_left == 0) m_done_cyc = cyc + READ_LAT + 1;
            end else if (start && !busy_now) begin
                if (piece_num == 0 || row_num == 0) begin
                    m_done_cyc = cyc + READ_LAT + 1;
                end else begin
                    m_left = int'(piece_num) * int'(row_num);
                    for (int r = 0; r < int'(row_num); r++) begin
                        for (int p = 0; p < int'(piece_num); p++) begin
                            rd_t e;
                            e.addr = (int'(addr_start) + r * int'(row_pitch) + p * int'(stride)) & AMASK;
                            e.last = (r == int'(row_num) - 1) && (p == int'(piece_num) - 1);
                            exp_q.push_back(e);
                        end
                    end
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (!rst) begin
            ren_e = ((m_left > 0) && !stall) ? 1 : 0;
            chk("ren", int'(ren), ren_e);
            if (m_left > 0) begin
                if (exp_q.size() == 0) begin
                    chk("queue_underflow", 0, 1);
                end else begin
                    chk("raddr", int'(raddr), exp_q[0].addr);
                    chk("last", int'(last), (ren_e != 0 && exp_q[0].last) ? 1 : 0);
                end
            end else begin
                chk("last_idle", int'(last), 0);
            end
            if (ren && exp_q.size() > 0) void'(exp_q.pop_front());
            chk("dvalid", int'(dvalid), int'(dly[READ_LAT-1]));
            chk("done", int'(done), (cyc == m_done_cyc) ? 1 : 0);
            chk("busy", int'(busy), m_busy() ? 1 : 0);
        end
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_ren"}, int'(ren), 0);
        chk({tag, "_raddr"}, int'(raddr), 0);
        chk({tag, "_last"}, int'(last), 0);
        chk({tag, "_dvalid"}, int'(dvalid), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // Issues one region from posedge+1 and returns in its done cycle, so a
    // following call starts back-to-back.
    task automatic run_region(input int a, input int pn, input int rn, input int st,
                              input int pit, input int stall_pct, input int sfrom,
                              input int slen, input int extra_at);
        bit seen;
        seen       = 1'b0;
        addr_start = ADDR_W'(a);
        piece_num  = CNT_W'(pn);
        row_num    = CNT_W'(rn);
        stride     = STRIDE_W'(st);
        row_pitch  = ADDR_W'(pit);
        start      = 1'b1;
        $display("region addr=0x%03h pieces=%0d rows=%0d stride=%0d pitch=0x%03h stall%%=%0d",
                 a & AMASK, pn, rn, st, pit & AMASK, stall_pct);
        @(posedge clk); #1;
        start      = 1'b0;
        addr_start = ADDR_W'($urandom);
        piece_num  = CNT_W'($urandom);
        row_num    = CNT_W'($urandom);
        stride     = STRIDE_W'($urandom);
        row_pitch  = ADDR_W'($urandom);
        for (int k = 1; k <= 4000; k++) begin
            stall = (k >= sfrom && k < sfrom + slen) || (int'($urandom_range(99)) < stall_pct);
            if (k == extra_at) begin
                start      = 1'b1;
                piece_num  = 8'd7;
                row_num    = 8'd7;
                addr_start = ADDR_W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        stall = 1'b0;
        start = 1'b0;
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        idle_cycles(2);
        check_zero_outputs("post_reset");

        run_region(12'h010, 4, 1, 1, 0, 0, 0, 0, 0);
        run_region(12'h100, 3, 2, 2, 12'h020, 0, 0, 0, 0);
        idle_cycles(1);
        run_region(12'h010, 4, 1, 1, 0, 0, 2, 3, 0);
        run_region(12'h050, 0, 3, 1, 0, 0, 0, 0, 0);
        run_region(12'h050, 5, 0, 1, 0, 0, 0, 0, 0);
        run_region(12'hFFE, 4, 1, 1, 0, 0, 0, 0, 0);
        run_region(12'h300, 5, 2, 3, 12'h040, 0, 0, 0, 2);
        run_region(12'h0A0, 1, 4, 5, 12'h010, 0, 0, 0, 0);
        run_region(12'h0C0, 3, 2, 0, 12'hFF0, 0, 0, 0, 0);

        // Abort in the middle of the third read.
        addr_start = 12'h200;
        piece_num  = 8'd5;
        row_num    = 8'd1;
        stride     = 4'd1;
        row_pitch  = '0;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idle_cycles(2);
        chk("ren_third_read", int'(ren), 1);
        chk("raddr_third_read", int'(raddr), 12'h202);
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycles(4);
        run_region(12'h200, 3, 1, 1, 0, 0, 0, 0, 0);

        for (int n = 0; n < 16; n++) begin
            int pn, rn;
            pn = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(1, 6));
            rn = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(1, 4));
            run_region(int'($urandom_range(AMASK)), pn, rn, int'($urandom_range(15)),
                       int'($urandom_range(AMASK)), 30, 0, 0, 0);
            idle_cycles(int'($urandom_range(0, 2)));
        end
        run_region(12'h7F0, 20, 10, 7, 12'h123, 20, 0, 0, 0);

        idle_cycles(5);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
